// File: rtl/aes_pkg.sv
// Shared AES constants: key/word/byte widths, round-key schedule FSM
// encoding and the Rcon table used by the inverse key expansion.
package aes_pkg;

  localparam int KEY_W   = 128;
  localparam int WORD_W  = 32;
  localparam int BYTE_W  = 8;
  localparam int ROUND_W = 4;
  localparam int NB      = KEY_W / WORD_W;

  localparam logic [ROUND_W-1:0] LAST_ROUND = 4'd10;

  typedef enum logic [1:0] {
    IKE_IDLE = 2'd0,
    IKE_EMIT = 2'd1,
    IKE_SUB  = 2'd2,
    IKE_MIX  = 2'd3
  } ike_state_e;

  // Rcon indexed by round number; entries outside 1..10 are never used.
  localparam logic [15:0][BYTE_W-1:0] RCON_TAB = {
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h36, 8'h1b, 8'h80, 8'h40, 8'h20,
    8'h10, 8'h08, 8'h04, 8'h02, 8'h01,
    8'h00
  };

  function automatic logic [BYTE_W-1:0] rcon(input logic [ROUND_W-1:0] r);
    return RCON_TAB[r];
  endfunction

endpackage

// File: rtl/SubBytes.sv
// AES forward S-box, one byte, purely combinational lookup.
module SubBytes (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  // Row-major S-box, entry 0x00 in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Byte at index din sits at bit offset 8*(255-din).
  always_comb begin
    dout = SBOX[8*(255 - int'(din)) +: 8];
  end

endmodule

// File: rtl/inv_key_expansion.sv
// AES-128 reverse key schedule: given the round-10 key, emits round keys
// 10 down to 0 with a valid/ready handshake. One S-box is time-shared over
// four SUB cycles per round, then MIX commits the previous round key.
// Optional build macro: INV_KEY_EXP_ERR_EN adds a sticky err_o flag for
// start requests that arrive while a schedule is running.
module inv_key_expansion
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [KEY_W-1:0]   key_in,
  output logic [KEY_W-1:0]   round_key_o,
  output logic [ROUND_W-1:0] round_o,
  output logic               valid_o,
  input  logic               ready_i,
  output logic               busy_o,
  output logic               done_o
`ifdef INV_KEY_EXP_ERR_EN
  ,
  output logic               err_o
`endif
);

  ike_state_e          state_q, state_d;
  logic [KEY_W-1:0]    key_q;
  logic [ROUND_W-1:0]  round_q;
  logic [1:0]          cnt_q;
  logic [WORD_W-1:0]   sw_q;
  logic                done_q;

  logic [WORD_W-1:0]   w0, w1, w2, w3;
  logic [WORD_W-1:0]   p0, p1, p2, p3;
  logic [1:0]          sel;
  logic [BYTE_W-1:0]   sb_in, sb_out;
  logic                hs, last_hs;

  assign w0 = key_q[127:96];
  assign w1 = key_q[95:64];
  assign w2 = key_q[63:32];
  assign w3 = key_q[31:0];

  // Previous-round words; p0 uses the SubWord(RotWord(p3)) gathered in SUB.
  assign p3 = w3 ^ w2;
  assign p2 = w2 ^ w1;
  assign p1 = w1 ^ w0;
  assign p0 = w0 ^ sw_q ^ {rcon(round_q), 24'h0};

  assign hs      = (state_q == IKE_EMIT) && ready_i;
  assign last_hs = hs && (round_q == '0);

  // RotWord: rotated byte k is p3 byte k+1 (mod 4).
  assign sel = cnt_q + 2'd1;

  // Pick the p3 byte fed to the shared S-box this SUB cycle.
  always_comb begin
    sb_in = p3[31:24];
    case (sel)
      2'd0: sb_in = p3[31:24];
      2'd1: sb_in = p3[23:16];
      2'd2: sb_in = p3[15:8];
      2'd3: sb_in = p3[7:0];
      default: sb_in = p3[31:24];
    endcase
  end

  SubBytes u_sbox (
    .din  (sb_in),
    .dout (sb_out)
  );

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IKE_IDLE: if (start) state_d = IKE_EMIT;
      IKE_EMIT: if (ready_i) state_d = (round_q == '0) ? IKE_IDLE : IKE_SUB;
      IKE_SUB:  if (cnt_q == 2'd3) state_d = IKE_MIX;
      IKE_MIX:  state_d = IKE_EMIT;
      default:  state_d = IKE_IDLE;
    endcase
  end

  // State register, key datapath and done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IKE_IDLE;
      key_q   <= '0;
      round_q <= '0;
      cnt_q   <= '0;
      sw_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= last_hs;
      case (state_q)
        IKE_IDLE: begin
          if (start) begin
            key_q   <= key_in;
            round_q <= LAST_ROUND;
            cnt_q   <= '0;
          end
        end
        IKE_SUB: begin
          case (cnt_q)
            2'd0: sw_q[31:24] <= sb_out;
            2'd1: sw_q[23:16] <= sb_out;
            2'd2: sw_q[15:8]  <= sb_out;
            2'd3: sw_q[7:0]   <= sb_out;
            default: ;
          endcase
          cnt_q <= cnt_q + 2'd1;
        end
        IKE_MIX: begin
          key_q   <= {p0, p1, p2, p3};
          round_q <= round_q - 4'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef INV_KEY_EXP_ERR_EN
  logic err_q;

  // Sticky flag for start requests that collide with a running schedule.
  always_ff @(posedge clk) begin
    if (!rst_n)                 err_q <= 1'b0;
    else if (start && busy_o)   err_q <= 1'b1;
  end

  assign err_o = err_q;
`endif

  assign round_key_o = key_q;
  assign round_o     = round_q;
  assign valid_o     = (state_q == IKE_EMIT);
  assign busy_o      = (state_q != IKE_IDLE);
  assign done_o      = done_q;

endmodule

// File: tb/tb_inv_key_expansion.sv
// Self-checking bench for inv_key_expansion. The reference derives all
// round keys by running the forward AES-128 key expansion from a round-0
// key, using an S-box computed from GF(2^8) inversion plus the affine map.
module tb_inv_key_expansion;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] key_in;
  logic [127:0] round_key_o;
  logic [3:0]   round_o;
  logic         valid_o;
  logic         ready_i;
  logic         busy_o;
  logic         done_o;
`ifdef INV_KEY_EXP_ERR_EN
  logic         err_o;
`endif

  int tests = 0;
  int fails = 0;

  logic [7:0]   tb_sbox [256];
  logic [127:0] model_rk [11];

  logic [127:0] obs_key [11];
  int           obs_round [11];
  int           obs_cyc [11];
  int           n_obs;
  int           done_cyc;
  bit           obs_done_valid, obs_done_busy, timed_out;

  inv_key_expansion dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .key_in      (key_in),
    .round_key_o (round_key_o),
    .round_o     (round_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .busy_o      (busy_o),
    .done_o      (done_o)
`ifdef INV_KEY_EXP_ERR_EN
    ,
    .err_o       (err_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    logic hi;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      hi = aa[7];
      aa = {aa[6:0], 1'b0};
      if (hi) aa = aa ^ 8'h1b;
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    logic [7:0] y;
    y = x;
    for (int i = 0; i < n; i++) y = {y[6:0], y[7]};
    return y;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      tb_sbox[a] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subword(input logic [31:0] x);
    return {tb_sbox[x[31:24]], tb_sbox[x[23:16]], tb_sbox[x[15:8]], tb_sbox[x[7:0]]};
  endfunction

  // Forward FIPS-197 expansion from round-0 key; fills model_rk[0..10].
  task automatic expand(input logic [127:0] k0);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    w[0] = k0[127:96]; w[1] = k0[95:64]; w[2] = k0[63:32]; w[3] = k0[31:0];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++)
      model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Drives one schedule starting at the current negedge and records every
  // accepted key; returns at the negedge where done_o is seen.
  task automatic run_sched(input logic [127:0] key, input bit bp, input int inj_round);
    bit injected;
    n_obs = 0; done_cyc = -1; timed_out = 1; injected = 0;
    obs_done_valid = 1'b1; obs_done_busy = 1'b1;
    start = 1'b1; key_in = key; ready_i = 1'b1;
    for (int cyc = 1; cyc <= 3000; cyc++) begin
      @(negedge clk);
      start = 1'b0; key_in = key;
      if (done_o) begin
        done_cyc = cyc; obs_done_valid = valid_o; obs_done_busy = busy_o;
        timed_out = 0;
        break;
      end
      if (valid_o) begin
        ready_i = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (ready_i) begin
          if (n_obs < 11) begin
            obs_key[n_obs] = round_key_o; obs_round[n_obs] = int'(round_o); obs_cyc[n_obs] = cyc;
          end
          n_obs++;
        end
        if (!injected && int'(round_o) == inj_round) begin
          start = 1'b1; key_in = '0; injected = 1;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; ready_i = 1'b1;
    key_in = 128'hffeeddccbbaa99887766554433221100;
    repeat (3) @(negedge clk);
    tests++;
    if (round_key_o !== '0 || round_o !== 4'd0 || valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: key=%h round=%0d valid=%b busy=%b done=%b, required all zero",
               round_key_o, round_o, valid_o, busy_o, done_o);
    end
`ifdef INV_KEY_EXP_ERR_EN
    tests++;
    if (err_o !== 1'b0) begin fails++; $display("FAIL reset_err: err_o=%b required 0", err_o); end
`endif
    start = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (busy_o !== 1'b0 || valid_o !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset: busy=%b valid=%b required 0 0", busy_o, valid_o);
    end
  endtask

  task automatic check_all(input string name);
    tests++;
    if (timed_out || n_obs != 11) begin
      fails++;
      $display("FAIL %s_count: keys=%0d timeout=%0d, required 11 keys no timeout", name, n_obs, timed_out);
    end
    for (int i = 0; i < 11 && i < n_obs; i++) begin
      tests++;
      if (obs_round[i] != 10 - i || obs_key[i] !== model_rk[10-i]) begin
        fails++;
        $display("FAIL %s_round%0d: got round %0d key %h, required round %0d key %h",
                 name, i, obs_round[i], obs_key[i], 10 - i, model_rk[10-i]);
      end
    end
  endtask

  task automatic test_fips();
    expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
    @(negedge clk);
    run_sched(128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 0, -1);
    check_all("fips");
    tests++;
    if (obs_key[0] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6 ||
        obs_key[1] !== 128'hac7766f319fadc2128d12941575c006e ||
        obs_key[10] !== 128'h2b7e151628aed2a6abf7158809cf4f3c) begin
      fails++;
      $display("FAIL fips_vectors: r10=%h r9=%h r0=%h", obs_key[0], obs_key[1], obs_key[10]);
    end
    for (int i = 0; i < 11; i++) begin
      tests++;
      if (obs_cyc[i] != 1 + 6 * i) begin
        fails++;
        $display("FAIL latency_key%0d: valid at cycle %0d, required %0d", i, obs_cyc[i], 1 + 6 * i);
      end
    end
    tests++;
    if (done_cyc != 62 || obs_done_valid !== 1'b0 || obs_done_busy !== 1'b0) begin
      fails++;
      $display("FAIL done_cycle: done at %0d valid=%b busy=%b, required 62 0 0",
               done_cyc, obs_done_valid, obs_done_busy);
    end
    @(negedge clk);
    tests++;
    if (done_o !== 1'b0) begin fails++; $display("FAIL done_pulse: done_o=%b one cycle later, required 0", done_o); end
  endtask

  task automatic test_random();
    logic [127:0] k0;
    for (int it = 0; it < 4; it++) begin
      k0 = {$urandom, $urandom, $urandom, $urandom};
      expand(k0);
      @(negedge clk);
      run_sched(model_rk[10], 1, -1);
      check_all("random");
    end
  endtask

  task automatic test_backpressure();
    bit held, got4, fin;
    expand({$urandom, $urandom, $urandom, $urandom});
    held = 0; got4 = 0; fin = 0;
    @(negedge clk);
    start = 1'b1; key_in = model_rk[10]; ready_i = 1'b1;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done_o) begin fin = 1; break; end
      if (valid_o && round_o == 4'd5 && !held) begin
        ready_i = 1'b0;
        for (int h = 0; h < 7; h++) begin
          @(negedge clk);
          tests++;
          if (valid_o !== 1'b1 || round_o !== 4'd5 || round_key_o !== model_rk[5]) begin
            fails++;
            $display("FAIL hold_cycle%0d: valid=%b round=%0d key=%h, required 1 5 %h",
                     h, valid_o, round_o, round_key_o, model_rk[5]);
          end
        end
        ready_i = 1'b1; held = 1;
      end else if (valid_o && round_o == 4'd4 && !got4) begin
        got4 = 1;
        tests++;
        if (round_key_o !== model_rk[4]) begin
          fails++;
          $display("FAIL resume_round4: key=%h required %h", round_key_o, model_rk[4]);
        end
      end
    end
    tests++;
    if (!held || !got4 || !fin) begin
      fails++;
      $display("FAIL backpressure_flow: held=%0d round4=%0d done=%0d, required 1 1 1", held, got4, fin);
    end
  endtask

  task automatic test_midrun_reset();
    bit seen7, hit;
    int sub_cnt;
    logic [127:0] k10;
    expand({$urandom, $urandom, $urandom, $urandom});
    k10 = model_rk[10];
    seen7 = 0; hit = 0; sub_cnt = 0;
    @(negedge clk);
    start = 1'b1; key_in = k10; ready_i = 1'b1;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (seen7 && !valid_o) sub_cnt++;
      if (sub_cnt == 2) begin hit = 1; break; end
      if (valid_o && round_o == 4'd7) seen7 = 1;
    end
    tests++;
    if (!hit || busy_o !== 1'b1 || valid_o !== 1'b0) begin
      fails++;
      $display("FAIL reach_sub7: reached=%0d busy=%b valid=%b, required 1 1 0", hit, busy_o, valid_o);
    end
    rst_n = 1'b0;
    @(negedge clk);
    tests++;
    if (round_key_o !== '0 || round_o !== 4'd0 || valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
      fails++;
      $display("FAIL midrun_reset: key=%h round=%0d valid=%b busy=%b done=%b, required all zero",
               round_key_o, round_o, valid_o, busy_o, done_o);
    end
    rst_n = 1'b1;
    @(negedge clk);
    run_sched(k10, 0, -1);
    check_all("rerun");
  endtask

  task automatic test_start_busy();
    expand({$urandom, $urandom, $urandom, $urandom});
    @(negedge clk);
    run_sched(model_rk[10], 0, 3);
    check_all("start_busy");
`ifdef INV_KEY_EXP_ERR_EN
    tests++;
    if (err_o !== 1'b1) begin fails++; $display("FAIL err_set: err_o=%b required 1", err_o); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tests++;
    if (err_o !== 1'b0) begin fails++; $display("FAIL err_clear: err_o=%b required 0", err_o); end
`endif
  endtask

  task automatic test_back_to_back();
    logic [127:0] ka10;
    expand({$urandom, $urandom, $urandom, $urandom});
    ka10 = model_rk[10];
    @(negedge clk);
    run_sched(ka10, 0, -1);
    check_all("b2b_first");
    expand({$urandom, $urandom, $urandom, $urandom});
    run_sched(model_rk[10], 0, -1);
    check_all("b2b_second");
    tests++;
    if (n_obs < 1 || obs_cyc[0] != 1) begin
      fails++;
      $display("FAIL b2b_latency: first valid at cycle %0d, required 1", obs_cyc[0]);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; ready_i = 1'b0; key_in = '0;
    build_sbox();
    test_reset();
    test_fips();
    test_random();
    test_backpressure();
    test_midrun_reset();
    test_start_busy();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/inv_key_expansion.md
INV_KEY_EXPANSION -- requirements
Module: inv_key_expansion

Interface
REQ-001 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, synchronous and active-low.
REQ-003 SHALL have port: start  input  1  request to begin a reverse schedule, sampled only in IDLE.
REQ-004 SHALL have port: key_in  input  128  round-10 key, FIPS-197 byte order (key_in[127:120] = byte 0, w0 = key_in[127:96]).
REQ-005 SHALL have port: round_key_o  output  128  current round key, same byte order as key_in.
REQ-006 SHALL have port: round_o  output  4  round index of round_key_o (10 down to 0).
REQ-007 SHALL have port: valid_o  output  1  round_key_o/round_o valid.
REQ-008 SHALL have port: ready_i  input  1  consumer accepts the key when valid_o && ready_i at a rising edge.
REQ-009 SHALL have port: busy_o  output  1  high in every state except IDLE.
REQ-010 SHALL have port: done_o  output  1  one-cycle pulse after round 0 is accepted.

Function
REQ-011 SHALL implement states IDLE, EMIT, SUB, MIX; IDLE->EMIT on start, EMIT->SUB on handshake when round_o>0, EMIT->IDLE on handshake when round_o==0, SUB->MIX after 4 cycles, MIX->EMIT after 1 cycle.
REQ-012 SHALL, on start in IDLE, load key_in into the key register, set round_o=10, and assert valid_o in the next cycle.
REQ-013 SHALL hold round_key_o, round_o and valid_o stable while valid_o=1 and ready_i=0.
REQ-014 SHALL, for current words w0..w3, compute previous words p3=w3^w2, p2=w2^w1, p1=w1^w0, p0=w0^SubWord(RotWord(p3))^Rcon(round_o).
REQ-015 SHALL substitute one byte per SUB cycle through a single shared S-box instance, byte counter 0..3, RotWord order p3 bytes 1,2,3,0.
REQ-016 SHALL apply Rcon only to the most significant byte of p0; Rcon(1..10)=01,02,04,08,10,20,40,80,1B,36.
REQ-017 SHALL commit p0..p3 and decrement round_o in MIX; handshake-to-next-valid_o latency is exactly 5 cycles.
REQ-018 SHALL pulse done_o for one cycle in the cycle following the round-0 handshake, with valid_o=0 and busy_o=0 in that cycle.
REQ-019 SHALL ignore start while busy_o=1; key register and sequence unaffected.
REQ-020 SHALL ignore ready_i while valid_o=0.
REQ-021 SHALL accept start in the same cycle done_o is asserted (back-to-back schedules).

Reset
REQ-022 SHALL, when rst_n=0 at a rising edge, enter IDLE and clear key register, byte counter, round_o, valid_o, busy_o and done_o to 0, including mid-schedule.
REQ-023 SHALL give reset priority over start and ready_i in the same cycle.

Configuration
REQ-024 SHALL, with INV_KEY_EXP_ERR_EN defined, add output err_o (1 bit) that sets when start=1 while busy_o=1 and stays set until reset.
REQ-025 SHALL, without INV_KEY_EXP_ERR_EN, have no err_o port and identical behaviour otherwise.

Structure
REQ-026 SHALL take the Rcon table, state encoding, key/word/byte width constants from shared package aes_pkg.
REQ-027 SHALL instantiate the existing SubBytes module (8-bit in, 8-bit out, combinational) once as its only sub-module.

Verification
REQ-028 FIPS-197 A.1: start with key_in=d014f9a8c9ee2589e13f0cc8b6630ca6, ready_i=1 -> first valid round 10 equals key_in, next round 9 = ac7766f319fadc2128d12941575c006e, round 0 = 2b7e151628aed2a6abf7158809cf4f3c, then done_o pulse.
REQ-029 Backpressure: ready_i=0 for 7 cycles at round 5 -> round_key_o/round_o unchanged, valid_o held; sequence resumes with correct round 4.
REQ-030 Latency: ready_i=1 always -> 11 keys, valid_o spacing 6 cycles, total start-to-done_o = 1+10*6+1 cycles.
REQ-031 Mid-run reset: rst_n=0 during SUB of round 7 -> next cycle IDLE, all outputs 0; new start with same key reproduces round 10..0 exactly.
REQ-032 Start while busy: start pulsed with key_in=0 at round 3 -> sequence unchanged; err_o=1 only when INV_KEY_EXP_ERR_EN defined.
REQ-033 Back-to-back: start asserted in done_o cycle with new key -> round 10 of new key valid next cycle.
